// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter for pipeline WB, load response and mul/div results.
// Optional anti-starvation promotion is enabled with `define RF_WB_ARB_STARVE_EN.
module rf_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_waddr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ready,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_waddr,
  input  logic [DATA_W-1:0] md_wdata,
  output logic              md_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              byp_valid,
  output logic [1:0]        starve_flag
);

  localparam logic [ADDR_W-1:0] X0 = {ADDR_W{1'b0}};

  logic pipe_req_s, ld_req_s, md_req_s;
  logic pipe_gnt_s, ld_gnt_s, md_gnt_s;
  logic ld_prom_s, md_prom_s;
  logic [1:0] starve_flag_d;

  logic              rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [1:0]        starve_flag_q;

  // x0 requests never compete; they are acked and dropped
  assign pipe_req_s = !rst && pipe_valid && (pipe_waddr != X0);
  assign ld_req_s   = !rst && ld_valid   && (ld_waddr   != X0);
  assign md_req_s   = !rst && md_valid   && (md_waddr   != X0);

`ifdef RF_WB_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] ld_wait_q, ld_wait_d;
  logic [3:0] md_wait_q, md_wait_d;

  assign ld_prom_s     = (ld_wait_q == STARVE_LIM);
  assign md_prom_s     = (md_wait_q == STARVE_LIM);
  assign starve_flag_d = {md_prom_s, ld_prom_s};

  always_comb begin
    ld_wait_d = 4'd0;
    md_wait_d = 4'd0;
    if (ld_req_s && !ld_gnt_s) begin
      ld_wait_d = ld_prom_s ? ld_wait_q : ld_wait_q + 4'd1;
    end else begin
      ld_wait_d = 4'd0;
    end
    if (md_req_s && !md_gnt_s) begin
      md_wait_d = md_prom_s ? md_wait_q : md_wait_q + 4'd1;
    end else begin
      md_wait_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_wait_q <= 4'd0;
      md_wait_q <= 4'd0;
    end else begin
      ld_wait_q <= ld_wait_d;
      md_wait_q <= md_wait_d;
    end
  end
`else
  assign ld_prom_s     = 1'b0;
  assign md_prom_s     = 1'b0;
  assign starve_flag_d = 2'b00;
`endif

  // Promoted ld, then promoted md, then fixed pipe > ld > md
  always_comb begin
    pipe_gnt_s = 1'b0;
    ld_gnt_s   = 1'b0;
    md_gnt_s   = 1'b0;
    if (ld_req_s && ld_prom_s) begin
      ld_gnt_s = 1'b1;
    end else if (md_req_s && md_prom_s) begin
      md_gnt_s = 1'b1;
    end else if (pipe_req_s) begin
      pipe_gnt_s = 1'b1;
    end else if (ld_req_s) begin
      ld_gnt_s = 1'b1;
    end else if (md_req_s) begin
      md_gnt_s = 1'b1;
    end else begin
      pipe_gnt_s = 1'b0;
    end
  end

  assign pipe_ready = !rst && pipe_valid && ((pipe_waddr == X0) || pipe_gnt_s);
  assign ld_ready   = !rst && ld_valid   && ((ld_waddr   == X0) || ld_gnt_s);
  assign md_ready   = !rst && md_valid   && ((md_waddr   == X0) || md_gnt_s);

  always_comb begin
    rf_wen_d   = pipe_gnt_s || ld_gnt_s || md_gnt_s;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_gnt_s) begin
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (ld_gnt_s) begin
      rf_waddr_d = ld_waddr;
      rf_wdata_d = ld_wdata;
    end else if (md_gnt_s) begin
      rf_waddr_d = md_waddr;
      rf_wdata_d = md_wdata;
    end else begin
      rf_waddr_d = rf_waddr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q      <= 1'b0;
      rf_waddr_q    <= X0;
      rf_wdata_q    <= {DATA_W{1'b0}};
      starve_flag_q <= 2'b00;
    end else begin
      rf_wen_q      <= rf_wen_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      starve_flag_q <= starve_flag_d;
    end
  end

  assign rf_wen      = rf_wen_q;
  assign byp_valid   = rf_wen_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign starve_flag = starve_flag_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a request-level model predicts readies and
// the ordered stream of register-file writes; a monitor checks the write port.
module tb_rf_wb_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_valid, ld_valid, md_valid;
  logic [AW-1:0] pipe_waddr, ld_waddr, md_waddr;
  logic [DW-1:0] pipe_wdata, ld_wdata, md_wdata;
  logic          pipe_ready, ld_ready, md_ready;
  logic          rf_wen, byp_valid;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    starve_flag;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(MAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_ready(pipe_ready),
    .ld_valid(ld_valid), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .md_valid(md_valid), .md_waddr(md_waddr), .md_wdata(md_wdata), .md_ready(md_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_valid(byp_valid), .starve_flag(starve_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } wr_t;
  wr_t exp_q[$];

  // Pending request per source: 0 = pipe, 1 = ld, 2 = md
  logic          p_v[3];
  logic [AW-1:0] p_a[3];
  logic [DW-1:0] p_d[3];
  bit            exp_rdy[3];
  int            wait_cnt[2];
  logic [1:0]    exp_flag = 2'b00;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit r);
    rst        = r;
    pipe_valid = p_v[0]; pipe_waddr = p_a[0]; pipe_wdata = p_d[0];
    ld_valid   = p_v[1]; ld_waddr   = p_a[1]; ld_wdata   = p_d[1];
    md_valid   = p_v[2]; md_waddr   = p_a[2]; md_wdata   = p_d[2];
  endtask

  task automatic new_req(input int i, input bit allow_x0);
    p_v[i] = 1'b1;
    p_d[i] = $urandom;
    if (allow_x0 && $urandom_range(5) == 0) p_a[i] = '0;
    else p_a[i] = AW'($urandom_range(31, 1));
  endtask

  // One clock cycle: present inputs, predict and compare, then retire accepted requests
  task automatic cycle(input bit r);
    bit req[3];
    int win;
    logic [1:0] nflag;
    drive(r);
    @(negedge clk);
    win = -1;
    for (int i = 0; i < 3; i++) req[i] = !r && p_v[i] && (p_a[i] != '0);
`ifdef RF_WB_ARB_STARVE_EN
    if (req[1] && wait_cnt[0] == MAX) win = 1;
    else if (req[2] && wait_cnt[1] == MAX) win = 2;
`endif
    for (int i = 0; i < 3; i++) if (win < 0 && req[i]) win = i;
    for (int i = 0; i < 3; i++) exp_rdy[i] = !r && p_v[i] && ((p_a[i] == '0) || (win == i));
    chk("pipe_ready", 64'(pipe_ready), 64'(exp_rdy[0]));
    chk("ld_ready",   64'(ld_ready),   64'(exp_rdy[1]));
    chk("md_ready",   64'(md_ready),   64'(exp_rdy[2]));
    chk("starve_flag", 64'(starve_flag), 64'(exp_flag));
    if (win >= 0) exp_q.push_back('{a: p_a[win], d: p_d[win], cyc: cyc + 1});
    nflag = 2'b00;
`ifdef RF_WB_ARB_STARVE_EN
    if (!r) nflag = {wait_cnt[1] == MAX, wait_cnt[0] == MAX};
`endif
    for (int j = 0; j < 2; j++) begin
      if (!r && req[j+1] && win != j + 1) wait_cnt[j] = (wait_cnt[j] < MAX) ? wait_cnt[j] + 1 : MAX;
      else wait_cnt[j] = 0;
    end
    exp_flag = nflag;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (exp_rdy[i]) p_v[i] = 1'b0;
  endtask

  // Monitor: every cycle the write port must match the head of the expected stream
  initial begin : monitor
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    bit exp_wen;
    wr_t e;
    last_a = '0;
    last_d = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      exp_wen = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("rf_wen", 64'(rf_wen), 64'(exp_wen));
      chk("byp_valid", 64'(byp_valid), 64'(exp_wen));
      if (exp_wen) begin
        e = exp_q.pop_front();
        last_a = e.a;
        last_d = e.d;
      end
      chk("rf_waddr", 64'(rf_waddr), 64'(last_a));
      chk("rf_wdata", 64'(rf_wdata), 64'(last_d));
    end
  end

  initial begin : stim
    int pct;
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;
    for (int i = 0; i < 3; i++) begin
      p_v[i] = 1'b1; p_a[i] = AW'(i + 1); p_d[i] = 32'hA5A5_0000 + 32'(i);
    end
    drive(1'b1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    for (int i = 0; i < 3; i++) p_v[i] = 1'b0;

    // Single pipeline write
    p_v[0] = 1'b1; p_a[0] = 5'd5; p_d[0] = 32'hDEAD_BEEF;
    cycle(1'b0); cycle(1'b0); cycle(1'b0);

    // All three sources at once
    p_v[0] = 1'b1; p_a[0] = 5'd3; p_d[0] = 32'h0000_0003;
    p_v[1] = 1'b1; p_a[1] = 5'd4; p_d[1] = 32'h0000_0004;
    p_v[2] = 1'b1; p_a[2] = 5'd6; p_d[2] = 32'h0000_0006;
    for (int k = 0; k < 5; k++) cycle(1'b0);

    // x0 filter alongside a real load write
    p_v[0] = 1'b1; p_a[0] = 5'd0; p_d[0] = 32'h1111_1111;
    p_v[1] = 1'b1; p_a[1] = 5'd7; p_d[1] = 32'h7777_7777;
    cycle(1'b0); cycle(1'b0); cycle(1'b0);

    // Sustained pipe traffic against a waiting load
    p_v[1] = 1'b1; p_a[1] = 5'd9; p_d[1] = 32'h9999_0009;
    for (int k = 0; k < 50; k++) begin
      if (!p_v[0]) new_req(0, 1'b0);
      cycle(1'b0);
    end
    for (int k = 0; k < 4; k++) cycle(1'b0);

    // Randomized traffic with varying pipeline load
    pct = 60;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) pct = $urandom_range(100, 30);
      if (!p_v[0] && $urandom_range(99) < pct) new_req(0, 1'b1);
      if (!p_v[1] && $urandom_range(99) < 40) new_req(1, 1'b1);
      if (!p_v[2] && $urandom_range(99) < 35) new_req(2, 1'b1);
      cycle(1'b0);
    end

    for (int k = 0; k < 40 && (p_v[0] || p_v[1] || p_v[2]); k++) cycle(1'b0);
    cycle(1'b0); cycle(1'b0); cycle(1'b0);
    chk("requests_drained", 64'(p_v[0] || p_v[1] || p_v[2]), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
